// File: rtl/maccum_share_arbiter.sv
// maccum_share_arbiter
//   Shares one BackwardMaccum datapath among NR backward-pass requesters.
//   Grants round-robin and holds the grant for a whole transaction:
//   capture request, issue weight/delta, collect Accum2, return the result.
//   Only one transaction is ever in flight.
//
// Ports
//   iCLK, iRST            clock, synchronous active-high reset
//   iValid_AM_Req/oReady  per-requester request handshake (NR bits)
//   iData_AM_Weight       NR weight slices, requester k in slice k
//   iData_AM_Delta0       NR delta slices, requester k in slice k
//   *_BM_Weight           weight channel towards the maccum
//   *_BM_Delta0           delta channel towards the maccum
//   *_AM_Accum2           result channel from the maccum
//   *_BM_Accum2           result return; valid is one-hot on the grant
//   oGrant                current or last grant index
//   oBusy                 high whenever a transaction is in progress
module maccum_share_arbiter #(
  parameter int NR = 4,
  parameter int NN = 7,
  parameter int NC = 11,
  parameter int WF = 5,
  localparam int WA = $clog2(NN) + WF,
  localparam int WI = (NR > 1) ? $clog2(NR) : 1,
  localparam int WW = NC * NN * WF,
  localparam int WD = NN * WF,
  localparam int WR = NC * WA
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [NR-1:0]    iValid_AM_Req,
  output logic [NR-1:0]    oReady_AM_Req,
  input  logic [NR*WW-1:0] iData_AM_Weight,
  input  logic [NR*WD-1:0] iData_AM_Delta0,
  output logic             oValid_BM_Weight,
  input  logic             iReady_BM_Weight,
  output logic [WW-1:0]    oData_BM_Weight,
  output logic             oValid_BM_Delta0,
  input  logic             iReady_BM_Delta0,
  output logic [WD-1:0]    oData_BM_Delta0,
  input  logic             iValid_AM_Accum2,
  output logic             oReady_AM_Accum2,
  input  logic [WR-1:0]    iData_AM_Accum2,
  output logic [NR-1:0]    oValid_BM_Accum2,
  input  logic [NR-1:0]    iReady_BM_Accum2,
  output logic [WR-1:0]    oData_BM_Accum2,
  output logic [WI-1:0]    oGrant,
  output logic             oBusy
);

  typedef enum logic [1:0] {stIdle, stIssue, stWait, stReturn} stateT;

  stateT         state, stateNext;
  logic [WI-1:0] ptr, ptrNext;
  logic [WI-1:0] grant, grantNext;
  logic [WI-1:0] pick;
  logic          pickValid;
  logic          wSent, wSentNext, dSent, dSentNext;
  logic          wXfer, dXfer, accXfer;
  logic [WW-1:0] weightReg;
  logic [WD-1:0] deltaReg;
  logic [WR-1:0] accumReg;

  // Round-robin search starting at ptr. Walking the offsets from the far
  // end down lets the nearest requester overwrite any farther one.
  always_comb begin
    pickValid = 1'b0;
    pick      = '0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (iValid_AM_Req[(int'(ptr) + i) % NR]) begin
        pickValid = 1'b1;
        pick      = WI'((int'(ptr) + i) % NR);
      end
    end
  end

  assign wXfer   = oValid_BM_Weight & iReady_BM_Weight;
  assign dXfer   = oValid_BM_Delta0 & iReady_BM_Delta0;
  assign accXfer = oReady_AM_Accum2 & iValid_AM_Accum2;

  // Next-state logic. The sent flags are merged with this cycle's handshake
  // so a simultaneous weight+delta transfer moves straight on to WAIT.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    grantNext = grant;
    wSentNext = wSent;
    dSentNext = dSent;
    case (state)
      stIdle: begin
        if (pickValid) begin
          grantNext = pick;
          stateNext = stIssue;
        end
      end
      stIssue: begin
        wSentNext = wSent | wXfer;
        dSentNext = dSent | dXfer;
        if (wSentNext && dSentNext) stateNext = stWait;
      end
      stWait: begin
        if (accXfer) stateNext = stReturn;
      end
      stReturn: begin
        if (iReady_BM_Accum2[grant]) begin
          ptrNext   = (int'(grant) == NR - 1) ? '0 : grant + 1'b1;
          wSentNext = 1'b0;
          dSentNext = 1'b0;
          stateNext = stIdle;
        end
      end
      default: stateNext = stIdle;
    endcase
  end

  // State register, pointer, grant and sent flags.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= stIdle;
      ptr   <= '0;
      grant <= '0;
      wSent <= 1'b0;
      dSent <= 1'b0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
      grant <= grantNext;
      wSent <= wSentNext;
      dSent <= dSentNext;
    end
  end

  // Payload registers; they only load on an accepted transfer so the
  // output buses hold their last value while the matching valid is low.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      weightReg <= '0;
      deltaReg  <= '0;
      accumReg  <= '0;
    end else begin
      if (state == stIdle && pickValid) begin
        weightReg <= iData_AM_Weight[int'(pick) * WW +: WW];
        deltaReg  <= iData_AM_Delta0[int'(pick) * WD +: WD];
      end
      if (accXfer) accumReg <= iData_AM_Accum2;
    end
  end

  // One-hot request accept and result valid decoding.
  always_comb begin
    oReady_AM_Req    = '0;
    oValid_BM_Accum2 = '0;
    for (int k = 0; k < NR; k++) begin
      oReady_AM_Req[k]    = (state == stIdle) && pickValid && (int'(pick) == k);
      oValid_BM_Accum2[k] = (state == stReturn) && (int'(grant) == k);
    end
  end

  assign oValid_BM_Weight = (state == stIssue) && !wSent;
  assign oValid_BM_Delta0 = (state == stIssue) && !dSent;
  assign oReady_AM_Accum2 = (state == stWait);
  assign oData_BM_Weight  = weightReg;
  assign oData_BM_Delta0  = deltaReg;
  assign oData_BM_Accum2  = accumReg;
  assign oGrant           = grant;
  assign oBusy            = (state != stIdle);

endmodule

// File: tb/tb_maccum_share_arbiter.sv
// tb_maccum_share_arbiter
//   Directed self-checking bench for maccum_share_arbiter (NR=4).
//   The bench plays both the requesters and the maccum peer; every
//   expected value comes from the slices and tags the bench itself drove.
module tb_maccum_share_arbiter;

  localparam int NR = 4;
  localparam int NN = 7;
  localparam int NC = 11;
  localparam int WF = 5;
  localparam int WA = $clog2(NN) + WF;
  localparam int WI = $clog2(NR);
  localparam int WW = NC * NN * WF;
  localparam int WD = NN * WF;
  localparam int WR = NC * WA;

  logic             iCLK = 1'b0;
  logic             iRST;
  logic [NR-1:0]    iValid_AM_Req;
  logic [NR-1:0]    oReady_AM_Req;
  logic [NR*WW-1:0] iData_AM_Weight;
  logic [NR*WD-1:0] iData_AM_Delta0;
  logic             oValid_BM_Weight;
  logic             iReady_BM_Weight;
  logic [WW-1:0]    oData_BM_Weight;
  logic             oValid_BM_Delta0;
  logic             iReady_BM_Delta0;
  logic [WD-1:0]    oData_BM_Delta0;
  logic             iValid_AM_Accum2;
  logic             oReady_AM_Accum2;
  logic [WR-1:0]    iData_AM_Accum2;
  logic [NR-1:0]    oValid_BM_Accum2;
  logic [NR-1:0]    iReady_BM_Accum2;
  logic [WR-1:0]    oData_BM_Accum2;
  logic [WI-1:0]    oGrant;
  logic             oBusy;

  int errors = 0;
  int checks = 0;
  int wXferCount = 0;
  int dXferCount = 0;

  logic [WW-1:0] wSlice [NR];
  logic [WD-1:0] dSlice [NR];
  logic [WR-1:0] tag;

  maccum_share_arbiter #(.NR(NR), .NN(NN), .NC(NC), .WF(WF)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AM_Req(iValid_AM_Req), .oReady_AM_Req(oReady_AM_Req),
    .iData_AM_Weight(iData_AM_Weight), .iData_AM_Delta0(iData_AM_Delta0),
    .oValid_BM_Weight(oValid_BM_Weight), .iReady_BM_Weight(iReady_BM_Weight),
    .oData_BM_Weight(oData_BM_Weight),
    .oValid_BM_Delta0(oValid_BM_Delta0), .iReady_BM_Delta0(iReady_BM_Delta0),
    .oData_BM_Delta0(oData_BM_Delta0),
    .iValid_AM_Accum2(iValid_AM_Accum2), .oReady_AM_Accum2(oReady_AM_Accum2),
    .iData_AM_Accum2(iData_AM_Accum2),
    .oValid_BM_Accum2(oValid_BM_Accum2), .iReady_BM_Accum2(iReady_BM_Accum2),
    .oData_BM_Accum2(oData_BM_Accum2),
    .oGrant(oGrant), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  // Handshakes seen at the negative edge complete on the following rising
  // edge, because the bench only changes inputs just after a rising edge.
  always @(negedge iCLK) begin
    if (!iRST) begin
      if (oValid_BM_Weight && iReady_BM_Weight) wXferCount++;
      if (oValid_BM_Delta0 && iReady_BM_Delta0) dXferCount++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < NR; k++) begin
      iData_AM_Weight[k*WW +: WW] = wSlice[k];
      iData_AM_Delta0[k*WD +: WD] = dSlice[k];
    end
  endtask

  task automatic fillSlices();
    for (int k = 0; k < NR; k++) begin
      for (int b = 0; b < WW; b++) wSlice[k][b] = 1'($urandom_range(0, 1));
      for (int b = 0; b < WD; b++) dSlice[k][b] = 1'($urandom_range(0, 1));
    end
    applyStimulus();
  endtask

  task automatic doReset();
    iRST = 1'b1;
    iValid_AM_Req = '0;
    tick();
    tick();
    iRST = 1'b0;
  endtask

  // All outputs must be at their reset values (requests held low).
  task automatic checkIdleZero(input string name);
    #1;
    checks++;
    if ({oReady_AM_Req, oValid_BM_Weight, oValid_BM_Delta0, oReady_AM_Accum2,
         oValid_BM_Accum2, oBusy} !== '0) begin
      errors++;
      $display("[TB] FAIL %s_ctrl: got req=%b vw=%b vd=%b ra=%b va=%b busy=%b want all 0", name,
               oReady_AM_Req, oValid_BM_Weight, oValid_BM_Delta0, oReady_AM_Accum2,
               oValid_BM_Accum2, oBusy);
    end
    checks++;
    if (oGrant !== '0) begin
      errors++;
      $display("[TB] FAIL %s_grant: got %0d want 0", name, oGrant);
    end
    checks++;
    if (oData_BM_Weight !== '0 || oData_BM_Delta0 !== '0 || oData_BM_Accum2 !== '0) begin
      errors++;
      $display("[TB] FAIL %s_data: got w=%h d=%h a=%h want 0", name,
               oData_BM_Weight, oData_BM_Delta0, oData_BM_Accum2);
    end
  endtask

  task automatic test_reset();
    doReset();
    checkIdleZero("reset");
  endtask

  // Single request from requester 2 with all-ones payload; fixed 4-cycle latency.
  task automatic test_single();
    wSlice[2] = '1;
    dSlice[2] = '1;
    applyStimulus();
    tag = WR'({$urandom, $urandom, $urandom});
    iData_AM_Accum2 = tag;
    iValid_AM_Accum2 = 1'b1;
    iReady_BM_Weight = 1'b1;
    iReady_BM_Delta0 = 1'b1;
    iReady_BM_Accum2 = '1;
    iValid_AM_Req = 4'b0100;
    #1;
    checks++;
    if (oReady_AM_Req !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL single_accept: got %b want 0100", oReady_AM_Req);
    end
    tick();
    iValid_AM_Req = '0;
    #1;
    checks++;
    if ({oValid_BM_Weight, oValid_BM_Delta0, oReady_AM_Accum2} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL single_issue: got vw/vd/ra=%b want 110",
               {oValid_BM_Weight, oValid_BM_Delta0, oReady_AM_Accum2});
    end
    checks++;
    if (oData_BM_Weight !== {WW{1'b1}} || oData_BM_Delta0 !== {WD{1'b1}}) begin
      errors++;
      $display("[TB] FAIL single_payload: got w=%h d=%h want all ones", oData_BM_Weight,
               oData_BM_Delta0);
    end
    checks++;
    if (oGrant !== 2'd2 || oBusy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_grant: got grant=%0d busy=%b want 2 1", oGrant, oBusy);
    end
    tick();
    checks++;
    if ({oValid_BM_Weight, oValid_BM_Delta0, oReady_AM_Accum2} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL single_wait: got vw/vd/ra=%b want 001",
               {oValid_BM_Weight, oValid_BM_Delta0, oReady_AM_Accum2});
    end
    tick();
    checks++;
    if (oValid_BM_Accum2 !== 4'b0100 || oData_BM_Accum2 !== tag) begin
      errors++;
      $display("[TB] FAIL single_return: got v=%b d=%h want 0100 %h", oValid_BM_Accum2,
               oData_BM_Accum2, tag);
    end
    tick();
    checks++;
    if (oBusy !== 1'b0 || oValid_BM_Accum2 !== '0) begin
      errors++;
      $display("[TB] FAIL single_done: got busy=%b v=%b want 0 0000", oBusy, oValid_BM_Accum2);
    end
  endtask

  // All four requesters held valid for eight back-to-back transactions.
  task automatic test_round_robin();
    logic [NR-1:0] expOh;
    int expIdx;
    doReset();
    fillSlices();
    wXferCount = 0;
    dXferCount = 0;
    iReady_BM_Weight = 1'b1;
    iReady_BM_Delta0 = 1'b1;
    iValid_AM_Accum2 = 1'b1;
    iReady_BM_Accum2 = '1;
    iValid_AM_Req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      expIdx = n % NR;
      expOh = '0;
      expOh[expIdx] = 1'b1;
      #1;
      checks++;
      if (oReady_AM_Req !== expOh) begin
        errors++;
        $display("[TB] FAIL rr_accept[%0d]: got %b want %b", n, oReady_AM_Req, expOh);
      end
      tick();
      checks++;
      if (int'(oGrant) != expIdx || oData_BM_Weight !== wSlice[expIdx] ||
          oData_BM_Delta0 !== dSlice[expIdx]) begin
        errors++;
        $display("[TB] FAIL rr_issue[%0d]: got grant=%0d want %0d or payload differs", n,
                 oGrant, expIdx);
      end
      tag = WR'({$urandom, $urandom, $urandom});
      iData_AM_Accum2 = tag;
      tick();
      tick();
      checks++;
      if (oValid_BM_Accum2 !== expOh || oData_BM_Accum2 !== tag) begin
        errors++;
        $display("[TB] FAIL rr_return[%0d]: got v=%b d=%h want %b %h", n, oValid_BM_Accum2,
                 oData_BM_Accum2, expOh, tag);
      end
      tick();
    end
    iValid_AM_Req = '0;
    checks++;
    if (wXferCount != 8 || dXferCount != 8) begin
      errors++;
      $display("[TB] FAIL rr_xfer_count: got w=%0d d=%0d want 8 8", wXferCount, dXferCount);
    end
  endtask

  // Weight ready held low for three ISSUE cycles while delta goes at once.
  task automatic test_skewed_issue();
    wXferCount = 0;
    dXferCount = 0;
    iReady_BM_Weight = 1'b0;
    iReady_BM_Delta0 = 1'b1;
    iValid_AM_Accum2 = 1'b1;
    iReady_BM_Accum2 = '0;
    iValid_AM_Req = 4'b0001;
    #1;
    checks++;
    if (oReady_AM_Req !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL skew_accept: got %b want 0001", oReady_AM_Req);
    end
    tick();
    iValid_AM_Req = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (oValid_BM_Weight !== 1'b1 || oValid_BM_Delta0 !== (i == 0) ||
          oReady_AM_Accum2 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL skew_hold[%0d]: got vw=%b vd=%b ra=%b want 1 %b 0", i,
                 oValid_BM_Weight, oValid_BM_Delta0, oReady_AM_Accum2, i == 0);
      end
      tick();
    end
    iReady_BM_Weight = 1'b1;
    #1;
    checks++;
    if (oValid_BM_Weight !== 1'b1 || oValid_BM_Delta0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL skew_release: got vw=%b vd=%b want 1 0", oValid_BM_Weight,
               oValid_BM_Delta0);
    end
    tick();
    tag = WR'({$urandom, $urandom, $urandom});
    iData_AM_Accum2 = tag;
    #1;
    checks++;
    if (oReady_AM_Accum2 !== 1'b1 || oValid_BM_Weight !== 1'b0 || oValid_BM_Delta0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL skew_wait: got ra=%b vw=%b vd=%b want 1 0 0", oReady_AM_Accum2,
               oValid_BM_Weight, oValid_BM_Delta0);
    end
    tick();
    checks++;
    if (oValid_BM_Accum2 !== 4'b0001 || oData_BM_Accum2 !== tag) begin
      errors++;
      $display("[TB] FAIL skew_return: got v=%b d=%h want 0001 %h", oValid_BM_Accum2,
               oData_BM_Accum2, tag);
    end
    iReady_BM_Accum2 = 4'b0001;
    tick();
    checks++;
    if (oBusy !== 1'b0 || wXferCount != 1 || dXferCount != 1) begin
      errors++;
      $display("[TB] FAIL skew_single_xfer: got busy=%b w=%0d d=%0d want 0 1 1", oBusy,
               wXferCount, dXferCount);
    end
  endtask

  // Requester 1 withholds result ready for ten cycles; peers' readies ignored.
  task automatic test_backpressure();
    iReady_BM_Weight = 1'b1;
    iReady_BM_Delta0 = 1'b1;
    iValid_AM_Accum2 = 1'b1;
    iReady_BM_Accum2 = 4'b1101;
    iValid_AM_Req = 4'b0010;
    tick();
    iValid_AM_Req = '0;
    tick();
    tag = WR'({$urandom, $urandom, $urandom});
    iData_AM_Accum2 = tag;
    tick();
    iValid_AM_Req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      iData_AM_Accum2 = WR'({$urandom, $urandom, $urandom});
      #1;
      checks++;
      if (oValid_BM_Accum2 !== 4'b0010 || oData_BM_Accum2 !== tag || oBusy !== 1'b1 ||
          oReady_AM_Req !== '0 || oGrant !== 2'd1) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b busy=%b req=%b grant=%0d d=%h want 0010 1 0000 1 %h",
                 i, oValid_BM_Accum2, oBusy, oReady_AM_Req, oGrant, oData_BM_Accum2, tag);
      end
      tick();
    end
    iReady_BM_Accum2 = 4'b0010;
    tick();
    checks++;
    if (oReady_AM_Req !== 4'b0100 || oData_BM_Accum2 !== tag) begin
      errors++;
      $display("[TB] FAIL bp_next_grant: got req=%b d=%h want 0100 %h", oReady_AM_Req,
               oData_BM_Accum2, tag);
    end
    iValid_AM_Req = '0;
  endtask

  // Reset asserted mid-ISSUE and mid-RETURN; pointer must restart at 0.
  task automatic test_reset_abort();
    iReady_BM_Weight = 1'b0;
    iReady_BM_Delta0 = 1'b1;
    iValid_AM_Accum2 = 1'b1;
    iReady_BM_Accum2 = '0;
    iValid_AM_Req = 4'b1000;
    tick();
    iValid_AM_Req = '0;
    #1;
    checks++;
    if (oValid_BM_Weight !== 1'b1 || oGrant !== 2'd3) begin
      errors++;
      $display("[TB] FAIL abort_issue: got vw=%b grant=%0d want 1 3", oValid_BM_Weight, oGrant);
    end
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    checkIdleZero("abort_issue_reset");
    iValid_AM_Req = 4'b1111;
    #1;
    checks++;
    if (oReady_AM_Req !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL abort_ptr_issue: got %b want 0001", oReady_AM_Req);
    end
    iReady_BM_Weight = 1'b1;
    tick();
    iValid_AM_Req = '0;
    tick();
    tag = WR'({$urandom, $urandom, $urandom});
    iData_AM_Accum2 = tag;
    tick();
    checks++;
    if (oValid_BM_Accum2 !== 4'b0001 || oData_BM_Accum2 !== tag) begin
      errors++;
      $display("[TB] FAIL abort_return: got v=%b d=%h want 0001 %h", oValid_BM_Accum2,
               oData_BM_Accum2, tag);
    end
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    checkIdleZero("abort_return_reset");
    iValid_AM_Req = 4'b0110;
    #1;
    checks++;
    if (oReady_AM_Req !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL abort_ptr_return: got %b want 0010", oReady_AM_Req);
    end
    iValid_AM_Req = '0;
  endtask

  initial begin
    iRST = 1'b1;
    iValid_AM_Req = '0;
    iReady_BM_Weight = 1'b0;
    iReady_BM_Delta0 = 1'b0;
    iValid_AM_Accum2 = 1'b0;
    iData_AM_Accum2 = '0;
    iReady_BM_Accum2 = '0;
    fillSlices();
    test_reset();
    test_single();
    test_round_robin();
    test_skewed_issue();
    test_backpressure();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
